// File: rtl/pwm_multichannel.sv
// N-channel PWM generator on one shared time base.
// Features: clock prescaler, edge- or center-aligned counting, and shadowed duty
// registers that only take effect at period boundaries.
module pwm_multichannel #(
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [PRESCALE_W-1:0]        prescale,
    input  logic                         align_mode,
    input  logic [CHANNELS*WIDTH-1:0]    duty_in,
    input  logic                         duty_wr,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_start,
    output logic                         pending
);

    localparam int unsigned DW = CHANNELS * WIDTH;
    // Last counter value before a wrap / turnaround (MAX-1).
    localparam logic [WIDTH-1:0] TOP = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [PRESCALE_W-1:0] pcnt;
    logic [WIDTH-1:0]      cnt;
    logic                  dir_down;
    logic                  mode;
    logic [DW-1:0]         shadow;
    logic [DW-1:0]         active;

    logic                  tick_c;
    logic [WIDTH-1:0]      cnt_nxt_c;
    logic                  dir_nxt_c;
    logic                  boundary_c;
    logic [CHANNELS-1:0]   cmp_c;

    // A prescale lowered below the running pcnt ticks at once rather than
    // wrapping through the whole pcnt range.
    assign tick_c = (pcnt >= prescale);

    // Next counter position and direction for the latched alignment mode.
    always_comb begin
        cnt_nxt_c = cnt;
        dir_nxt_c = dir_down;
        if (!mode) begin
            cnt_nxt_c = (cnt == TOP) ? '0 : cnt + WIDTH'(1);
        end else if (!dir_down) begin
            if (cnt == TOP) dir_nxt_c = 1'b1;
            else            cnt_nxt_c = cnt + WIDTH'(1);
        end else begin
            if (cnt == '0)  dir_nxt_c = 1'b0;
            else            cnt_nxt_c = cnt - WIDTH'(1);
        end
    end

    // A period begins on the tick that lands the counter on 0 going up.
    assign boundary_c = enable & tick_c & (cnt_nxt_c == '0) & ~dir_nxt_c;

    // Per-channel duty compare against the current counter value.
    always_comb begin
        cmp_c = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            cmp_c[k] = (cnt < active[k*WIDTH +: WIDTH]);
        end
    end

    // Time base, shadow/active duty handling and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt         <= '0;
            cnt          <= '0;
            dir_down     <= 1'b0;
            mode         <= 1'b0;
            shadow       <= '0;
            active       <= '0;
            pending      <= 1'b0;
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            if (!enable) begin
                // Idle: park the time base and keep duty/mode current so the
                // first period after enable uses the latest values.
                pcnt         <= '0;
                cnt          <= '0;
                dir_down     <= 1'b0;
                pwm_out      <= '0;
                period_start <= 1'b0;
                active       <= shadow;
                mode         <= align_mode;
                pending      <= duty_wr;
            end else begin
                pcnt <= tick_c ? '0 : pcnt + PRESCALE_W'(1);
                if (tick_c) begin
                    cnt      <= cnt_nxt_c;
                    dir_down <= dir_nxt_c;
                end
                period_start <= boundary_c;
                if (boundary_c) begin
                    mode <= align_mode;
                    if (pending) active <= shadow;
                end
                // A write on the boundary cycle keeps pending set for the next period.
                pending <= duty_wr | (pending & ~boundary_c);
                pwm_out <= cmp_c;
            end
            if (duty_wr) shadow <= duty_in;
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: directed scenarios plus a random run
// against a period/position-based reference model.
module tb_pwm_multichannel;

    localparam int unsigned CH  = 3;
    localparam int unsigned W   = 8;
    localparam int unsigned PW  = 8;
    localparam int          MAX = 255;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [PW-1:0]     prescale;
    logic              align_mode;
    logic [CH*W-1:0]   duty_in;
    logic              duty_wr;
    logic [CH-1:0]     pwm_out;
    logic              period_start;
    logic              pending;

    int n_cmp;
    int n_fail;

    pwm_multichannel #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .prescale     (prescale),
        .align_mode   (align_mode),
        .duty_in      (duty_in),
        .duty_wr      (duty_wr),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Position within the period (in ticks) and the enabled-cycle count define
    // everything; the counter value is derived from the position.
    int              m_pos;
    int              m_cyc;
    logic            m_mode;
    logic [CH*W-1:0] m_act;
    logic [CH*W-1:0] m_sh;
    logic            m_pend;
    logic            m_ps;
    logic [CH-1:0]   m_pwm;
    logic            m_tick;
    logic            m_wrap;

    function automatic int period_f(input logic md);
        return md ? 2 * MAX : MAX;
    endfunction

    function automatic int cnt_f(input int pos, input logic md);
        if (!md || pos < MAX) return pos;
        return 2 * MAX - 1 - pos;
    endfunction

    assign m_tick = enable && (((m_cyc + 1) % (int'(prescale) + 1)) == 0);
    assign m_wrap = m_tick && ((m_pos + 1) == period_f(m_mode));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos  <= 0;
            m_cyc  <= 0;
            m_mode <= 1'b0;
            m_act  <= '0;
            m_sh   <= '0;
            m_pend <= 1'b0;
            m_ps   <= 1'b0;
            m_pwm  <= '0;
        end else if (!enable) begin
            m_pos  <= 0;
            m_cyc  <= 0;
            m_ps   <= 1'b0;
            m_pwm  <= '0;
            m_act  <= m_sh;
            m_mode <= align_mode;
            m_pend <= duty_wr;
            if (duty_wr) m_sh <= duty_in;
        end else begin
            m_cyc <= m_cyc + 1;
            for (int k = 0; k < int'(CH); k++)
                m_pwm[k] <= (cnt_f(m_pos, m_mode) < int'(m_act[k*W +: W]));
            m_ps <= m_wrap;
            if (m_tick) m_pos <= m_wrap ? 0 : m_pos + 1;
            if (m_wrap) begin
                m_mode <= align_mode;
                if (m_pend) m_act <= m_sh;
            end
            m_pend <= duty_wr || (m_pend && !m_wrap);
            if (duty_wr) m_sh <= duty_in;
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Disable, load mode/prescale/duty and let the idle commit reach active.
    task automatic configure(input int p, input logic md, input logic [CH*W-1:0] d);
        enable = 1'b0;
        step();
        prescale   = PW'(p);
        align_mode = md;
        duty_in    = d;
        duty_wr    = 1'b1;
        step();
        duty_wr = 1'b0;
        step();
        step();
    endtask

    task automatic wait_ps(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (period_start === 1'b1) ok = 1'b1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_cmp++; if (pwm_out !== 3'b000) begin n_fail++; $display("FAIL reset_pwm: got %b expected 000", pwm_out); end
        n_cmp++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps: got %b expected 0", period_start); end
        n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", pending); end
        configure(0, 1'b0, {8'd0, 8'd0, 8'd255});
        enable = 1'b1;
        for (int i = 0; i < 20; i++) step();
        duty_in = {8'd0, 8'd0, 8'd77};
        duty_wr = 1'b1;
        step();
        duty_wr = 1'b0;
        n_cmp++; if (pwm_out[0] !== 1'b1) begin n_fail++; $display("FAIL reset_pre_high: got %b expected 1", pwm_out[0]); end
        n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL reset_pre_pending: got %b expected 1", pending); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (pwm_out !== 3'b000) begin n_fail++; $display("FAIL reset_async_pwm: got %b expected 000", pwm_out); end
        n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_async_pending: got %b expected 0", pending); end
        #1 rst = 1'b0;
        begin
            int hi;
            hi = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (pwm_out !== 3'b000) hi++;
            end
            n_cmp++; if (hi !== 0) begin n_fail++; $display("FAIL reset_duty0: got %0d high cycles expected 0", hi); end
        end
        enable = 1'b0;
    endtask

    task automatic test_edge_duty();
        bit ok;
        int hi[CH];
        int exp_hi[CH];
        int ps_n;
        exp_hi = '{0, 128, 255};
        configure(0, 1'b0, {8'd255, 8'd128, 8'd0});
        enable = 1'b1;
        wait_ps(600, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL edge_wait_ps: got timeout expected period_start"); end
        foreach (hi[k]) hi[k] = 0;
        ps_n = 0;
        for (int i = 0; i < MAX; i++) begin
            step();
            for (int k = 0; k < int'(CH); k++) if (pwm_out[k] === 1'b1) hi[k]++;
            if (period_start === 1'b1) ps_n++;
        end
        for (int k = 0; k < int'(CH); k++) begin
            n_cmp++;
            if (hi[k] !== exp_hi[k]) begin n_fail++; $display("FAIL edge_high_ch%0d: got %0d expected %0d", k, hi[k], exp_hi[k]); end
        end
        n_cmp++; if (ps_n !== 1) begin n_fail++; $display("FAIL edge_ps_count: got %0d expected 1", ps_n); end
    endtask

    task automatic test_prescale_center();
        bit ok;
        int hi, rises, ps_n;
        logic prev;
        configure(3, 1'b1, {8'd0, 8'd0, 8'd64});
        enable = 1'b1;
        wait_ps(3000, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL center_wait_ps: got timeout expected period_start"); end
        hi = 0; rises = 0; ps_n = 0;
        prev = pwm_out[0];
        for (int i = 0; i < 2040; i++) begin
            step();
            if (pwm_out[0] === 1'b1) hi++;
            if (pwm_out[0] === 1'b1 && prev === 1'b0) rises++;
            prev = pwm_out[0];
            if (period_start === 1'b1) ps_n++;
        end
        n_cmp++; if (hi !== 512) begin n_fail++; $display("FAIL center_high: got %0d expected 512", hi); end
        n_cmp++; if (rises !== 1) begin n_fail++; $display("FAIL center_pulses: got %0d expected 1", rises); end
        n_cmp++; if (ps_n !== 1 || period_start !== 1'b1) begin n_fail++; $display("FAIL center_period: got %0d starts (last %b) expected 1 at 2040", ps_n, period_start); end
    endtask

    task automatic test_shadow();
        bit ok;
        int hi;
        configure(0, 1'b0, {8'd0, 8'd0, 8'd50});
        enable = 1'b1;
        wait_ps(600, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL shadow_wait_ps: got timeout expected period_start"); end
        hi = 0;
        for (int i = 1; i <= MAX; i++) begin
            step();
            if (pwm_out[0] === 1'b1) hi++;
            if (i == 150) begin
                n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL shadow_pending_mid: got %b expected 1", pending); end
            end
            if (i == MAX) begin
                n_cmp++; if (period_start !== 1'b1 || pending !== 1'b0) begin n_fail++; $display("FAIL shadow_commit: got ps=%b pending=%b expected ps=1 pending=0", period_start, pending); end
            end
            if (i == 100) begin duty_in = {8'd0, 8'd0, 8'd200}; duty_wr = 1'b1; end
            if (i == 101) duty_wr = 1'b0;
        end
        n_cmp++; if (hi !== 50) begin n_fail++; $display("FAIL shadow_old_period: got %0d expected 50", hi); end
        hi = 0;
        for (int i = 1; i <= MAX; i++) begin
            step();
            if (pwm_out[0] === 1'b1) hi++;
        end
        n_cmp++; if (hi !== 200) begin n_fail++; $display("FAIL shadow_new_period: got %0d expected 200", hi); end
    endtask

    task automatic test_collision();
        bit ok;
        int hi;
        configure(0, 1'b0, {8'd0, 8'd0, 8'd50});
        enable = 1'b1;
        wait_ps(600, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL coll_wait_ps: got timeout expected period_start"); end
        hi = 0;
        for (int i = 1; i <= MAX; i++) begin
            step();
            if (pwm_out[0] === 1'b1) hi++;
            if (i == MAX) begin
                n_cmp++; if (period_start !== 1'b1 || pending !== 1'b1) begin n_fail++; $display("FAIL coll_boundary: got ps=%b pending=%b expected ps=1 pending=1", period_start, pending); end
                duty_wr = 1'b0;
            end
            if (i == 50)  begin duty_in = {8'd0, 8'd0, 8'd100}; duty_wr = 1'b1; end
            if (i == 51)  duty_wr = 1'b0;
            if (i == 254) begin duty_in = {8'd0, 8'd0, 8'd150}; duty_wr = 1'b1; end
        end
        n_cmp++; if (hi !== 50) begin n_fail++; $display("FAIL coll_p1: got %0d expected 50", hi); end
        hi = 0;
        for (int i = 1; i <= MAX; i++) begin
            step();
            if (pwm_out[0] === 1'b1) hi++;
        end
        n_cmp++; if (hi !== 100) begin n_fail++; $display("FAIL coll_p2_old_shadow: got %0d expected 100", hi); end
        n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL coll_p2_pending: got %b expected 0", pending); end
        hi = 0;
        for (int i = 1; i <= MAX; i++) begin
            step();
            if (pwm_out[0] === 1'b1) hi++;
        end
        n_cmp++; if (hi !== 150) begin n_fail++; $display("FAIL coll_p3_new: got %0d expected 150", hi); end
    endtask

    task automatic test_enable();
        bit ok;
        int hi, ps_n, first_ps;
        configure(0, 1'b0, {8'd0, 8'd0, 8'd200});
        enable = 1'b1;
        wait_ps(600, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL en_wait_ps: got timeout expected period_start"); end
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (pwm_out[0] !== 1'b1) begin n_fail++; $display("FAIL en_pre_high: got %b expected 1", pwm_out[0]); end
        enable = 1'b0;
        step();
        n_cmp++; if (pwm_out !== 3'b000) begin n_fail++; $display("FAIL en_drop: got %b expected 000", pwm_out); end
        duty_in = {8'd0, 8'd0, 8'd10};
        duty_wr = 1'b1;
        step();
        duty_wr = 1'b0;
        step();
        step();
        enable = 1'b1;
        hi = 0; ps_n = 0; first_ps = 0;
        for (int i = 1; i <= MAX; i++) begin
            step();
            if (pwm_out[0] === 1'b1) hi++;
            if (period_start === 1'b1) begin
                ps_n++;
                if (first_ps == 0) first_ps = i;
            end
        end
        n_cmp++; if (hi !== 10) begin n_fail++; $display("FAIL en_first_period: got %0d expected 10", hi); end
        n_cmp++; if (ps_n !== 1 || first_ps !== MAX) begin n_fail++; $display("FAIL en_first_ps: got %0d starts first at %0d expected 1 at %0d", ps_n, first_ps, MAX); end
    endtask

    task automatic test_random();
        enable = 1'b0;
        duty_wr = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        prescale   = PW'($urandom_range(0, 2));
        align_mode = 1'($urandom_range(0, 1));
        duty_in    = CH*W'($urandom);
        step();
        enable = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            step();
            n_cmp++;
            if (pwm_out !== m_pwm) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rand_pwm @%0d: got %b expected %b", i, pwm_out, m_pwm);
            end
            n_cmp++;
            if (period_start !== m_ps) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rand_ps @%0d: got %b expected %b", i, period_start, m_ps);
            end
            n_cmp++;
            if (pending !== m_pend) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rand_pending @%0d: got %b expected %b", i, pending, m_pend);
            end
            duty_wr = ($urandom_range(0, 39) == 0);
            if (duty_wr) duty_in = CH*W'($urandom);
            if ($urandom_range(0, 299) == 0) align_mode = ~align_mode;
            if ($urandom_range(0, 1499) == 0) begin
                enable = ~enable;
                if (!enable) prescale = PW'($urandom_range(0, 2));
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        enable     = 1'b0;
        prescale   = '0;
        align_mode = 1'b0;
        duty_in    = '0;
        duty_wr    = 1'b0;
        step();
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_edge_duty();
        test_prescale_center();
        test_shadow();
        test_collision();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
